// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: default widths,
// ALU op codes, instruction field placement and FSM state encodings.
package alu_sequencer_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RA_W       = 3;
    localparam int DEF_OP_W       = 3;
    localparam int DEF_FIFO_DEPTH = 4;

    // ALU op codes; only OP_MUL changes sequencing (two-beat writeback)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    // Instruction word is {op, rd, ra, rb}; register fields sit in these
    // RA_W-wide slots counted from the LSB, op occupies the slot above rd.
    localparam int FLD_RB = 0;
    localparam int FLD_RA = 1;
    localparam int FLD_RD = 2;
    localparam int FLD_OP = 3;

    // Sequencer FSM encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB_LO  = 3'd3;
    localparam logic [2:0] ST_WB_HI  = 3'd4;

    // Width of a packed 3-address instruction
    function automatic int instr_width(input int op_w, input int ra_w);
        return op_w + 3 * ra_w;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer and its environment: instruction
// valid/ready channel, register-file ports and ALU op/result/flags.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RA_W   = DEF_RA_W,
    parameter int OP_W   = DEF_OP_W
);
    localparam int INSTR_W = instr_width(OP_W, RA_W);

    logic                  instr_valid;
    logic [INSTR_W-1:0]    instr_data;
    logic                  instr_ready;
    logic [RA_W-1:0]       rf_ra_addr;
    logic [RA_W-1:0]       rf_rb_addr;
    logic [OP_W-1:0]       alu_op;
    logic [2*DATA_W-1:0]   alu_result;
    logic                  alu_overflow;
    logic                  alu_c_out;
    logic                  rf_we;
    logic [RA_W-1:0]       rf_wr_addr;
    logic [DATA_W-1:0]     rf_wr_data;

    // Sequencer side
    modport slave (
        input  instr_valid, instr_data, alu_result, alu_overflow, alu_c_out,
        output instr_ready, rf_ra_addr, rf_rb_addr, alu_op,
               rf_we, rf_wr_addr, rf_wr_data
    );

    // Environment side: instruction source, register file and ALU
    modport master (
        output instr_valid, instr_data, alu_result, alu_overflow, alu_c_out,
        input  instr_ready, rf_ra_addr, rf_rb_addr, alu_op,
               rf_we, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/alu_instr_fifo.sv
// Synchronous instruction FIFO. Ready is registered so that it is low while
// reset is applied and rises on the first clock after release; afterwards
// it always equals !full. Storage is not reset, only pointers and count.
module alu_instr_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             ready_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;

    // Next pointers/occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
        ready_d = (count_d != CNT_FULL);
    end

    // Pointer, count and ready state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the ALU/register-file datapath. Instructions are
// queued in a small FIFO and executed strictly one at a time:
// IDLE -> DECODE -> EXEC -> WB_LO [-> WB_HI for multiply] -> IDLE.
// Every datapath-facing output is a register updated on the state transition
// into the state where it must be valid.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int              DATA_W     = DEF_DATA_W,
    parameter int              RA_W       = DEF_RA_W,
    parameter int              OP_W       = DEF_OP_W,
    parameter int              FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [OP_W-1:0] MUL_OP     = OP_W'(OP_MUL)
) (
    input  logic            clock,
    input  logic            reset_n,
    alu_sequencer_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            flag_ovf,
    output logic            flag_carry
);
    localparam int INSTR_W = instr_width(OP_W, RA_W);
    localparam int RB_LSB  = FLD_RB * RA_W;
    localparam int RA_LSB  = FLD_RA * RA_W;
    localparam int RD_LSB  = FLD_RD * RA_W;
    localparam int OP_LSB  = FLD_OP * RA_W;

    // Destination of the high byte of a multiply; wraps past the last register
    function automatic logic [RA_W-1:0] next_reg(input logic [RA_W-1:0] r);
        return r + RA_W'(1);
    endfunction

    logic [2:0]         state_q, state_d;
    logic [OP_W-1:0]    instr_op_q, instr_op_d;
    logic [RA_W-1:0]    instr_rd_q, instr_rd_d;
    logic [DATA_W-1:0]  res_hi_q, res_hi_d;
    logic [RA_W-1:0]    ra_q, ra_d;
    logic [RA_W-1:0]    rb_q, rb_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               we_q, we_d;
    logic [RA_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               carry_q, carry_d;

    logic               pop;
    logic [INSTR_W-1:0] fifo_rdata;
    logic               fifo_empty;
    logic               fifo_ready;

    alu_instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (bus.instr_valid),
        .wdata_i (bus.instr_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .ready_o (fifo_ready)
    );

    assign bus.instr_ready = fifo_ready;
    assign bus.rf_ra_addr  = ra_q;
    assign bus.rf_rb_addr  = rb_q;
    assign bus.alu_op      = op_q;
    assign bus.rf_we       = we_q;
    assign bus.rf_wr_addr  = wr_addr_q;
    assign bus.rf_wr_data  = wr_data_q;
    assign done            = done_q;
    assign flag_ovf        = ovf_q;
    assign flag_carry      = carry_q;
    assign busy            = (state_q != ST_IDLE) || !fifo_empty;

    // FSM next state and registered outputs for the state being entered
    always_comb begin
        state_d    = state_q;
        instr_op_d = instr_op_q;
        instr_rd_d = instr_rd_q;
        res_hi_d   = res_hi_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        op_d       = op_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        carry_d    = carry_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Pop and present read addresses for DECODE
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    instr_op_d = fifo_rdata[OP_LSB +: OP_W];
                    instr_rd_d = fifo_rdata[RD_LSB +: RA_W];
                    ra_d       = fifo_rdata[RA_LSB +: RA_W];
                    rb_d       = fifo_rdata[RB_LSB +: RA_W];
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d    = instr_op_q;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Result/flags sampled here; low byte goes straight to write data
                res_hi_d  = bus.alu_result[2*DATA_W-1:DATA_W];
                ovf_d     = bus.alu_overflow;
                carry_d   = bus.alu_c_out;
                we_d      = 1'b1;
                wr_addr_d = instr_rd_q;
                wr_data_d = bus.alu_result[DATA_W-1:0];
                done_d    = (op_q != MUL_OP);
                state_d   = ST_WB_LO;
            end
            ST_WB_LO: begin
                if (op_q == MUL_OP) begin
                    we_d      = 1'b1;
                    wr_addr_d = next_reg(instr_rd_q);
                    wr_data_d = res_hi_q;
                    done_d    = 1'b1;
                    state_d   = ST_WB_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB_HI: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any instruction in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            instr_op_q <= '0;
            instr_rd_q <= '0;
            res_hi_q   <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            op_q       <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_op_q <= instr_op_d;
            instr_rd_q <= instr_rd_d;
            res_hi_q   <= res_hi_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            op_q       <= op_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            carry_q    <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: environment register file and ALU,
// an instruction-level reference model, and directed plus random steps.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy, done, flag_ovf, flag_carry;

    alu_sequencer_if sif ();

    alu_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (sif),
        .busy       (busy),
        .done       (done),
        .flag_ovf   (flag_ovf),
        .flag_carry (flag_carry)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [7:0]  rf_env [8];
    logic [7:0]  ref_rf [8];
    logic [10:0] exp_wr [$];
    logic [1:0]  exp_fl [$];
    logic [17:0] alu_vec;
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [7:0]  load_data = '0;

    // Environment ALU: returns {overflow, carry, result[15:0]}
    function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] r;
        logic        c;
        logic        v;
        s = '0;
        r = {8'h00, a};
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = {8'h00, s[7:0]};
                c = s[8];
                v = (a[7] == b[7]) && (s[7] != a[7]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = {8'h00, s[7:0]};
                c = s[8];
                v = (a[7] != b[7]) && (s[7] != a[7]);
            end
            OP_MUL: begin
                r = 16'(a) * 16'(b);
                v = (r[15:8] != 8'h00);
            end
            OP_AND: r = {8'h00, a & b};
            OP_OR:  r = {8'h00, a | b};
            OP_XOR: r = {8'h00, a ^ b};
            default: r = {8'h00, a};
        endcase
        return {v, c, r};
    endfunction

    always_comb begin
        alu_vec = alu_fn(sif.alu_op, rf_env[sif.rf_ra_addr], rf_env[sif.rf_rb_addr]);
    end
    assign sif.alu_result   = alu_vec[15:0];
    assign sif.alu_c_out    = alu_vec[16];
    assign sif.alu_overflow = alu_vec[17];

    // Environment register file
    always @(posedge clock) begin
        if (load_en) rf_env[load_addr] <= load_data;
        else if (sif.rf_we) rf_env[sif.rf_wr_addr] <= sif.rf_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port and done monitors against the reference queues
    always @(negedge clock) begin
        if (reset_n && sif.rf_we) begin
            chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                chk("write_addr_data", {21'd0, sif.rf_wr_addr, sif.rf_wr_data},
                    {21'd0, exp_wr[0]});
                void'(exp_wr.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && done) begin
            done_cnt++;
            chk("done_with_write", 32'(sif.rf_we), 32'd1);
            chk("done_expected", 32'(exp_fl.size() != 0), 32'd1);
            if (exp_fl.size() != 0) begin
                chk("flags", {30'd0, flag_ovf, flag_carry}, {30'd0, exp_fl[0]});
                void'(exp_fl.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_reg(input logic [2:0] a, input logic [7:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        ref_rf[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    // Instruction-level reference: each instruction reads, computes, writes back in order
    task automatic model(input logic [11:0] ins);
        logic [2:0]  op, rd, ra, rb, rd1;
        logic [17:0] v;
        op  = ins[11:9];
        rd  = ins[8:6];
        ra  = ins[5:3];
        rb  = ins[2:0];
        rd1 = rd + 3'd1;
        v   = alu_fn(op, ref_rf[ra], ref_rf[rb]);
        exp_wr.push_back({rd, v[7:0]});
        ref_rf[rd] = v[7:0];
        if (op == OP_MUL) begin
            exp_wr.push_back({rd1, v[15:8]});
            ref_rf[rd1] = v[15:8];
        end
        exp_fl.push_back(v[17:16]);
        exp_done++;
    endtask

    task automatic push(input logic [11:0] ins, input bit use_model);
        int w;
        w = 0;
        sif.instr_valid = 1'b1;
        sif.instr_data  = ins;
        while (sif.instr_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("push_accept_wait", 32'(w < 100), 32'd1);
        tick();
        sif.instr_valid = 1'b0;
        if (use_model) model(ins);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((busy || exp_wr.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk({tag, "_drain"}, 32'(n < 300), 32'd1);
        chk({tag, "_done_count"}, done_cnt, exp_done);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_r%0d", tag, i), {24'd0, rf_env[i]}, {24'd0, ref_rf[i]});
        end
    endtask

    function automatic logic [11:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb};
    endfunction

    initial begin
        int found;
        int dc;
        sif.instr_valid = 1'b0;
        sif.instr_data  = '0;

        // Reset held while the environment register file is preset
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) load_reg(3'(i), 8'($urandom));
        load_reg(3'd1, 8'h7F);
        load_reg(3'd2, 8'h01);
        load_reg(3'd4, 8'h10);
        load_reg(3'd5, 8'h20);
        repeat (5) tick();
        chk("reset_outputs", {sif.rf_we, sif.rf_ra_addr, sif.rf_rb_addr, sif.alu_op,
                              sif.rf_wr_addr, sif.rf_wr_data, busy, done, flag_ovf, flag_carry},
            32'd0);
        chk("reset_ready", 32'(sif.instr_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("post_reset_ready", 32'(sif.instr_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // ADD r3 <= r1 + r2 with signed overflow
        push(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 1'b1);
        chk("add_busy_queued", 32'(busy), 32'd1);
        tick();
        chk("add_decode_ra", 32'(sif.rf_ra_addr), 32'd1);
        chk("add_decode_rb", 32'(sif.rf_rb_addr), 32'd2);
        chk("add_decode_we", 32'(sif.rf_we), 32'd0);
        tick();
        chk("add_exec_op", 32'(sif.alu_op), 32'(OP_ADD));
        chk("add_exec_ra_hold", 32'(sif.rf_ra_addr), 32'd1);
        chk("add_exec_done", 32'(done), 32'd0);
        tick();
        chk("add_wb_we", 32'(sif.rf_we), 32'd1);
        chk("add_wb_addr", 32'(sif.rf_wr_addr), 32'd3);
        chk("add_wb_data", 32'(sif.rf_wr_data), 32'h80);
        chk("add_done", 32'(done), 32'd1);
        chk("add_ovf", 32'(flag_ovf), 32'd1);
        chk("add_carry", 32'(flag_carry), 32'd0);
        tick();
        chk("add_after_we", 32'(sif.rf_we), 32'd0);
        chk("add_after_done", 32'(done), 32'd0);
        chk("add_after_busy", 32'(busy), 32'd0);
        chk("add_flag_hold", 32'(flag_ovf), 32'd1);
        drain("add");

        // MUL r7 <= r4 * r5, high byte wraps to r0
        push(enc(OP_MUL, 3'd7, 3'd4, 3'd5), 1'b1);
        tick();
        tick();
        chk("mul_exec_op", 32'(sif.alu_op), 32'(OP_MUL));
        tick();
        chk("mul_lo_we", 32'(sif.rf_we), 32'd1);
        chk("mul_lo_addr", 32'(sif.rf_wr_addr), 32'd7);
        chk("mul_lo_data", 32'(sif.rf_wr_data), 32'h00);
        chk("mul_lo_done", 32'(done), 32'd0);
        tick();
        chk("mul_hi_we", 32'(sif.rf_we), 32'd1);
        chk("mul_hi_addr", 32'(sif.rf_wr_addr), 32'd0);
        chk("mul_hi_data", 32'(sif.rf_wr_data), 32'h02);
        chk("mul_hi_done", 32'(done), 32'd1);
        tick();
        chk("mul_after_we", 32'(sif.rf_we), 32'd0);
        drain("mul");

        // Six back-to-back pushes against a four-entry FIFO
        for (int k = 0; k < 6; k++) begin
            push(12'($urandom), 1'b1);
            if (k < 4) chk($sformatf("burst_ready_%0d", k), 32'(sif.instr_ready), 32'd1);
            else if (k == 4) chk("burst_full", 32'(sif.instr_ready), 32'd0);
        end
        drain("burst");

        // Reset during the low writeback beat of a multiply with work queued
        dc = done_cnt;
        push(enc(OP_MUL, 3'd6, 3'd2, 3'd3), 1'b0);
        push(enc(OP_ADD, 3'd5, 3'd1, 3'd1), 1'b0);
        push(enc(OP_XOR, 3'd4, 3'd1, 3'd2), 1'b0);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            tick();
            if (sif.rf_we === 1'b1) found = 1;
        end
        chk("abort_reached_wb", found, 32'd1);
        chk("abort_wb_addr", 32'(sif.rf_wr_addr), 32'd6);
        reset_n = 1'b0;
        #1;
        chk("abort_we_async", 32'(sif.rf_we), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) tick();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(sif.instr_ready), 32'd1);
        chk("abort_no_done", done_cnt, dc);
        chk("abort_flags", {30'd0, flag_ovf, flag_carry}, 32'd0);
        drain("abort");

        // Idle gap between two isolated instructions
        push(enc(OP_SUB, 3'd2, 3'd6, 3'd7), 1'b1);
        drain("gap1");
        chk("gap_busy_low", 32'(busy), 32'd0);
        push(enc(OP_OR, 3'd1, 3'd2, 3'd0), 1'b1);
        drain("gap2");

        // Random stream with random inter-push gaps
        for (int k = 0; k < 24; k++) begin
            push(12'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain("random");
        chk("random_queues_empty", 32'(exp_fl.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
